flash_loader: RTL and testbench
===============================

# flash_loader

Boot-time copier that reads a contiguous image from the SPI flash and writes it word by word into `ramio`. It sits directly upstream of `ramio`: it drives the `ramio` request port and the flash SPI pins, then releases both when done. The CPU is held off until `done` rises.

## Interface
- `TransferByteCount`, 256: bytes to copy. Must be a multiple of 4 and at least 4.
- `FlashAddress`, 0: 24-bit flash byte address of the first byte copied.
- `RamAddress`, 0: `ramio` byte address of the first word written.

- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: a one-cycle pulse begins a copy. Ignored unless the block is in Idle or Done.
- `busy` output 1: high from the cycle after an accepted `start` until the last write completes.
- `done` output 1: high after a completed copy. Cleared by `rst` or by the next accepted `start`.
- `flash_clk` output 1: SPI clock, mode 0, running at `clk`/2.
- `flash_mosi` output 1: SPI data to flash, MSB first.
- `flash_miso` input 1: SPI data from flash.
- `flash_cs_n` output 1: flash chip select, active low.
- `ramio_enable` output 1: request strobe to `ramio`.
- `ramio_write_type` output 2: always 2'b11 (word) while `ramio_enable` is high, 0 otherwise.
- `ramio_read_type` output 3: always 0.
- `ramio_address` output 32: byte address of the write.
- `ramio_data_in` output 32: write data.
- `ramio_busy` input 1: `ramio` is processing a request.

## Operation
- States: Idle, SendCmd, SendAddr, ReadWord, Write, WaitWrite, Done.
- Idle/Done + `start`:
  - drive `flash_cs_n`=0;
  - load shift register with 8'h03;
  - go to SendCmd.
- Bit transmit (SendCmd, SendAddr): each bit takes 2 cycles.
  - Phase 0: `flash_clk`=0, `flash_mosi` = current MSB.
  - Phase 1: `flash_clk`=1 (flash samples), then shift left.
- SendCmd sends 8 bits, then SendAddr sends `FlashAddress` as 24 bits MSB first, then the block enters ReadWord.
- ReadWord receives 32 bits, 2 cycles each.
  - Phase 0: `flash_clk`=0.
  - Phase 1: `flash_clk`=1 and `flash_miso` is captured on the same edge.
  - Bits assemble MSB first into bytes. Byte k of the word (k=0..3, in arrival order) lands in `ramio_data_in[8k+7:8k]`, so the word is little-endian.
- Write, on entry:
  - hold `flash_clk`=0 and `flash_cs_n`=0; the SPI clock pauses and the flash stream resumes later;
  - when `ramio_busy`=0: assert `ramio_enable`=1 for exactly one cycle with `ramio_address` = `RamAddress` + 4·n, where n is the word index;
  - go to WaitWrite.
- WaitWrite:
  - the first cycle is unconditionally skipped (`ramio` registers `busy` on the edge that samples `enable`);
  - afterwards, stay while `ramio_busy`=1;
  - on `ramio_busy`=0: n++. If 4·n < `TransferByteCount`, go to ReadWord. Otherwise drive `flash_cs_n`=1, `busy`=0, `done`=1 and go to Done.
- Arithmetic:
  - word counter is 32 bits wide and wraps are impossible within legal parameters;
  - `ramio_address` increments by 4 with no alignment check.

## Timing
- Reset values (at the edge where `rst` is high, from any state): Idle; `flash_cs_n`=1, `flash_clk`=0, `flash_mosi`=0, `ramio_enable`=0, `ramio_write_type`=0, `ramio_read_type`=0, `ramio_address`=0, `ramio_data_in`=0, `busy`=0, `done`=0.
- Reset mid-copy:
  - chip select deasserts at that edge;
  - a partially assembled word is discarded;
  - no `ramio_enable` is issued afterwards.
- `start` at edge t gives `flash_cs_n`=0 and `busy`=1 at t+1.
- Command phase: 16 cycles. Address phase: 48 cycles.
- Each word: 64 cycles of ReadWord, plus at least 1 Write cycle, plus at least 2 WaitWrite cycles.
- With `ramio_busy` always 0: total = 1 + 16 + 48 + (TransferByteCount/4)·67 cycles from `start` to `done`.
- `ramio_enable` is never high on two consecutive cycles. It is never asserted while `ramio_busy`=1.
- `flash_mosi` changes only in cycles where `flash_clk` is driven 0.
- `start` while `busy` is ignored with no side effects.

## Test plan
- Command/address framing: `FlashAddress`=0, `start` pulse.
  - `flash_mosi` sampled at each `flash_clk` rise must read 0000_0011 followed by 24 zeros.
  - `flash_cs_n` falls one cycle after `start`.
- Full copy against the `flash` model loaded with ram.mem, `ramio` backed by SDRAM, 256 bytes.
  - Exactly 64 `ramio_enable` pulses with addresses 0,4,…,252.
  - `done`=1, `flash_cs_n`=1.
  - A subsequent `ramio` word read at address 16 returns 32'hD5B8A9C4, matching flash bytes C4,A9,B8,D5.
- Busy backpressure: a stub `ramio` holds `ramio_busy`=1 for 20 cycles after each enable.
  - No enable while busy.
  - `flash_clk` stays 0 during the stall.
  - Data integrity is identical to the unstalled run.
- Reset mid-word: assert `rst` during byte 2 of word 5.
  - Next cycle `flash_cs_n`=1, `ramio_enable`=0, `busy`=0, `done`=0.
  - A new `start` repeats the full copy correctly from word 0.
- `start` re-pulsed while `busy`: no restart; write count stays 64.
- Timing check: with `ramio_busy` tied 0, `done` rises exactly 4353 cycles after `start`.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: boot-time copier, SPI flash (cmd 0x03 read) -> ramio words.
// Ports: clk, rst (sync, active-high), start -> busy/done;
//   flash_clk/mosi/miso/cs_n: SPI mode 0 master at clk/2;
//   ramio_*: one-shot word write requests, held off by ramio_busy.
module flash_loader #(
    parameter int unsigned TransferByteCount = 256,
    parameter logic [23:0] FlashAddress      = 24'h0,
    parameter logic [31:0] RamAddress        = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs_n,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy
);

    localparam logic [31:0] WordCount = 32'(TransferByteCount / 4);

    typedef enum logic [2:0] {
        Idle, SendCmd, SendAddr, ReadWord, Write, WaitWrite, Done
    } state_t;

    state_t      state, state_nx;
    logic        phase;
    logic [4:0]  bit_cnt;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic [31:0] word_idx;
    logic        skip;
    logic        accept;
    logic        word_next;
    logic        shifting;

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        word_next    = 1'b0;
        ramio_enable = 1'b0;
        unique case (state)
            Idle, Done: begin
                if (start) begin
                    state_nx = SendCmd;
                    accept   = 1'b1;
                end
            end
            SendCmd: begin
                if (phase && bit_cnt == 5'd7)
                    state_nx = SendAddr;
            end
            SendAddr: begin
                if (phase && bit_cnt == 5'd23)
                    state_nx = ReadWord;
            end
            ReadWord: begin
                if (phase && bit_cnt == 5'd31)
                    state_nx = Write;
            end
            Write: begin
                if (!ramio_busy) begin
                    ramio_enable = 1'b1;
                    state_nx     = WaitWrite;
                end
            end
            WaitWrite: begin
                // ramio raises busy one cycle after it samples enable,
                // so the first cycle here must not trust ramio_busy.
                if (!skip && !ramio_busy) begin
                    word_next = 1'b1;
                    if (word_idx + 32'd1 < WordCount)
                        state_nx = ReadWord;
                    else
                        state_nx = Done;
                end
            end
            default: state_nx = Idle;
        endcase
    end

    assign shifting = (state == SendCmd) || (state == SendAddr)
                   || (state == ReadWord);

    assign busy             = (state != Idle) && (state != Done);
    assign done             = (state == Done);
    assign flash_cs_n       = !busy;
    // phase is forced low outside the shift states, so it is the SPI clock.
    assign flash_clk        = phase;
    // tx_shift drains to zero, so mosi idles low without extra gating.
    assign flash_mosi       = tx_shift[31];
    assign ramio_write_type = ramio_enable ? 2'b11 : 2'b00;
    assign ramio_read_type  = 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= Idle;
            phase         <= 1'b0;
            bit_cnt       <= 5'd0;
            tx_shift      <= 32'd0;
            rx_shift      <= 32'd0;
            word_idx      <= 32'd0;
            skip          <= 1'b0;
            ramio_address <= 32'd0;
            ramio_data_in <= 32'd0;
        end else begin
            state <= state_nx;
            skip  <= ramio_enable;

            if (accept) begin
                tx_shift      <= {8'h03, 24'h0};
                bit_cnt       <= 5'd0;
                phase         <= 1'b0;
                word_idx      <= 32'd0;
                ramio_address <= RamAddress;
            end

            if (shifting) begin
                phase <= ~phase;
                if (phase) begin
                    tx_shift <= {tx_shift[30:0], 1'b0};
                    if (state_nx != state)
                        bit_cnt <= 5'd0;
                    else
                        bit_cnt <= bit_cnt + 5'd1;
                end else if (state == ReadWord) begin
                    // Sample on the edge that raises flash_clk; the flash
                    // changed miso on the previous falling edge.
                    rx_shift <= {rx_shift[30:0], flash_miso};
                end
            end

            if (state == SendCmd && state_nx == SendAddr)
                tx_shift <= {FlashAddress, 8'h00};

            // First byte received sits in the top of rx_shift but
            // belongs in the low byte of the word.
            if (state == ReadWord && state_nx == Write)
                ramio_data_in <= {rx_shift[7:0], rx_shift[15:8],
                                  rx_shift[23:16], rx_shift[31:24]};

            if (word_next) begin
                word_idx      <= word_idx + 32'd1;
                ramio_address <= ramio_address + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: self-checking bench for flash_loader with a
// behavioural SPI flash, a stalling ramio stub and a write scoreboard.
module tb_flash_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso;
    logic        flash_cs_n;
    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address;
    logic [31:0] ramio_data_in;
    logic        ramio_busy;

    always #5 clk = ~clk;

    flash_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .flash_clk        (flash_clk),
        .flash_mosi       (flash_mosi),
        .flash_miso       (flash_miso),
        .flash_cs_n       (flash_cs_n),
        .ramio_enable     (ramio_enable),
        .ramio_write_type (ramio_write_type),
        .ramio_read_type  (ramio_read_type),
        .ramio_address    (ramio_address),
        .ramio_data_in    (ramio_data_in),
        .ramio_busy       (ramio_busy)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural flash: 32-bit header in, then a byte stream out.
    logic [7:0]  image [256];
    logic [31:0] hdr = 32'd0;
    int          rx_bits = 0;
    int          tx_bits = 0;

    initial flash_miso = 1'b0;

    always @(posedge flash_clk)
        if (!flash_cs_n && rx_bits < 32) begin
            hdr     = {hdr[30:0], flash_mosi};
            rx_bits = rx_bits + 1;
        end

    always @(negedge flash_clk)
        if (!flash_cs_n && rx_bits == 32) begin
            flash_miso = image[(tx_bits / 8) % 256][7 - (tx_bits % 8)];
            tx_bits    = tx_bits + 1;
        end

    always @(posedge flash_cs_n) begin
        rx_bits = 0;
        tx_bits = 0;
    end

    // ramio stub: busy for `stall` cycles after each accepted enable.
    int stall = 0;
    int bcnt  = 0;

    always @(posedge clk)
        if (ramio_enable)
            bcnt <= stall;
        else if (bcnt > 0)
            bcnt <= bcnt - 1;

    assign ramio_busy = (bcnt > 0);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] mem [64];
    int          writes = 0;
    int          viol = 0;
    logic        prev_en = 1'b0;
    logic        prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (ramio_enable && ramio_busy) viol++;
        if (ramio_enable && prev_en) viol++;
        if (ramio_busy && flash_clk) viol++;
        if (flash_clk && flash_mosi !== prev_mosi) viol++;
        if (ramio_write_type !== (ramio_enable ? 2'b11 : 2'b00)) viol++;
        if (ramio_read_type !== 3'b000) viol++;
        prev_en   = ramio_enable;
        prev_mosi = flash_mosi;
        if (ramio_enable) begin
            wr_t e;
            writes++;
            if (ramio_address < 32'd256)
                mem[ramio_address[7:2]] = ramio_data_in;
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'(ramio_enable), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", ramio_address, e.addr);
                chk("wr_data", ramio_data_in, e.data);
            end
        end
    end

    task automatic push_expected();
        for (int w = 0; w < 64; w++) begin
            wr_t e;
            e.addr = 32'(4 * w);
            e.data = {image[4*w+3], image[4*w+2],
                      image[4*w+1], image[4*w]};
            sb.push_back(e);
        end
    endtask

    task automatic run_copy(input int stl, input int restart_at,
                            input int exp_cyc);
        int n;
        bit pulsed;
        n      = 0;
        pulsed = 1'b0;
        stall  = stl;
        writes = 0;
        viol   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        push_expected();
        @(negedge clk);
        chk("cs_n_before_start", 32'(flash_cs_n), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("cs_n_after_start", 32'(flash_cs_n), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (restart_at >= 0 && writes == restart_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_reached", 32'(done), 32'd1);
        chk("done_cycles", 32'(n), 32'(exp_cyc));
        chk("write_count", 32'(writes), 32'd64);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("monitor_viol", 32'(viol), 32'd0);
        chk("spi_header", hdr, 32'h0300_0000);
        chk("cs_n_after_done", 32'(flash_cs_n), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ram_word16", mem[4], 32'hD5B8_A9C4);
        sb.delete();
    endtask

    typedef struct {
        int stall;
        int restart_at;
        int exp_cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{stall: 0,  restart_at: -1, exp_cyc: 4353};
        vecs[1] = '{stall: 20, restart_at: -1, exp_cyc: 5569};
        vecs[2] = '{stall: 0,  restart_at: 10, exp_cyc: 4353};
        vecs[3] = '{stall: 3,  restart_at: -1, exp_cyc: 4481};

        for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
        image[16] = 8'hC4;
        image[17] = 8'hA9;
        image[18] = 8'hB8;
        image[19] = 8'hD5;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(flash_cs_n), 32'd1);
        chk("rst_flash_clk", 32'(flash_clk), 32'd0);
        chk("rst_mosi", 32'(flash_mosi), 32'd0);
        chk("rst_enable", 32'(ramio_enable), 32'd0);
        chk("rst_write_type", 32'(ramio_write_type), 32'd0);
        chk("rst_read_type", 32'(ramio_read_type), 32'd0);
        chk("rst_address", ramio_address, 32'd0);
        chk("rst_data", ramio_data_in, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++)
            run_copy(vecs[v].stall, vecs[v].restart_at, vecs[v].exp_cyc);

        // Reset in the middle of byte 2 of word 5.
        stall  = 0;
        writes = 0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20000 && tx_bits < 5 * 32 + 20; i++)
            @(negedge clk);
        chk("mid_reached", 32'(tx_bits), 32'(5 * 32 + 20));
        chk("mid_writes", 32'(writes), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cs_n", 32'(flash_cs_n), 32'd1);
        chk("midrst_enable", 32'(ramio_enable), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_address", ramio_address, 32'd0);
        chk("midrst_data", ramio_data_in, 32'd0);
        chk("midrst_flash_clk", 32'(flash_clk), 32'd0);
        sb.delete();
        repeat (200) @(negedge clk);
        chk("midrst_no_writes", 32'(writes), 32'd5);
        run_copy(0, -1, 4353);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
